// File: rtl/rds_tx_pkg.sv
// Shared types and constants for the OOK frame keyer: FSM state encoding,
// Manchester chip pair, default sync byte and the holding-register payload.
package rds_tx_pkg;

  // FSM state encoding
  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_PREAMBLE = 3'd1;
  localparam logic [2:0] ST_SYNC     = 3'd2;
  localparam logic [2:0] ST_DATA     = 3'd3;
  localparam logic [2:0] ST_GAP      = 3'd4;

  // Chip pair {first, second} for a 1 bit; a 0 bit uses the complement
  localparam logic [1:0] MAN_ONE = 2'b10;

  localparam logic [7:0] SYNC_WORD_DEFAULT = 8'h2D;

  // Holding-register payload
  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } tx_byte_t;

  // Chip level for bit b in chip phase (0 = first chip of the bit)
  function automatic logic man_chip(input logic b, input logic phase);
    logic [1:0] pair;
    pair = b ? MAN_ONE : ~MAN_ONE;
    return phase ? pair[0] : pair[1];
  endfunction

endpackage

// File: rtl/ook_frame_keyer_if.sv
// Byte stream into the keyer.
//   tx_data  : payload byte, MSB first on air
//   tx_last  : final byte of the frame
//   tx_valid : byte offered by the master
//   tx_ready : keyer holding register is empty
interface ook_frame_keyer_if;
  logic [7:0] tx_data;
  logic       tx_last;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_last, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_last, input tx_valid, output tx_ready);
endinterface

// File: rtl/chip_timer.sv
// Chip-rate prescaler. Counts 0..CHIP_CYCLES-1 while enabled and pulses
// chip_tick (registered) during the wrap cycle, i.e. the last clock of a chip.
//   clk, reset_n : clock, async active-low reset
//   en           : run; held at count 0 while low
//   chip_tick    : high on the final clock of each chip
module chip_timer #(
  parameter int unsigned CHIP_CYCLES = 108480
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  output logic chip_tick
);

  localparam int unsigned CW = $clog2(CHIP_CYCLES);

  logic [CW-1:0] count;

  // Tick is registered one count early so it lines up with count == CHIP_CYCLES-1
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count     <= '0;
      chip_tick <= 1'b0;
    end else if (!en) begin
      count     <= '0;
      chip_tick <= 1'b0;
    end else begin
      count     <= (count == CW'(CHIP_CYCLES - 1)) ? '0 : count + CW'(1);
      chip_tick <= (count == CW'(CHIP_CYCLES - 2));
    end
  end

endmodule

// File: rtl/ook_frame_keyer.sv
// Frames byte payloads (preamble, sync byte, data, carrier-off gap) and
// Manchester-encodes them into an on/off-keying gate.
//   clk, reset_n : carrier PLL clock, async active-low reset
//   tx           : byte stream (slave side)
//   rf_gate      : registered carrier enable
//   busy         : not in IDLE
//   underrun     : one-cycle pulse when a data byte was due but none was held
module ook_frame_keyer
  import rds_tx_pkg::*;
#(
  parameter int unsigned CHIP_CYCLES   = 108480,
  parameter int unsigned PREAMBLE_BITS = 16,
  parameter logic [7:0]  SYNC_WORD     = SYNC_WORD_DEFAULT,
  parameter int unsigned GAP_CHIPS     = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  ook_frame_keyer_if.slave tx,
  output logic             rf_gate,
  output logic             busy,
  output logic             underrun
);

  localparam int unsigned BIT_MAX = (PREAMBLE_BITS > 8) ? PREAMBLE_BITS : 8;
  localparam int unsigned BW      = $clog2(BIT_MAX + 1);
  localparam int unsigned GW      = $clog2(GAP_CHIPS + 1);

  logic [2:0]    state, state_n;
  logic          phase, phase_n;
  logic [BW-1:0] bit_cnt, bit_cnt_n;
  logic [GW-1:0] gap_cnt, gap_cnt_n;
  logic [7:0]    shreg, shreg_n;
  logic          last_q, last_n;
  tx_byte_t      hold;
  logic          hold_full, hold_seen;
  logic          load_c, accept_c, run_c, chip_tick;
  logic          underrun_n, gate_n;

  assign tx.tx_ready = ~hold_full;
  assign accept_c    = tx.tx_valid & ~hold_full;
  assign run_c       = (state != ST_IDLE);

  chip_timer #(.CHIP_CYCLES(CHIP_CYCLES)) u_chip_timer (
    .clk       (clk),
    .reset_n   (reset_n),
    .en        (run_c),
    .chip_tick (chip_tick)
  );

  // Holding register; hold_seen delays the IDLE exit by one cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold      <= '0;
      hold_full <= 1'b0;
      hold_seen <= 1'b0;
    end else begin
      hold_seen <= hold_full;
      if (accept_c) begin
        hold      <= {tx.tx_data, tx.tx_last};
        hold_full <= 1'b1;
      end else if (load_c) begin
        hold_full <= 1'b0;
      end
    end
  end

  // Next-state logic; all sequencing advances only on chip_tick
  always_comb begin
    state_n    = state;
    phase_n    = phase;
    bit_cnt_n  = bit_cnt;
    gap_cnt_n  = gap_cnt;
    shreg_n    = shreg;
    last_n     = last_q;
    load_c     = 1'b0;
    underrun_n = 1'b0;
    gate_n     = 1'b0;

    case (state)
      ST_IDLE: begin
        if (hold_seen) begin
          state_n   = ST_PREAMBLE;
          phase_n   = 1'b0;
          bit_cnt_n = '0;
        end
      end
      ST_PREAMBLE: begin
        if (chip_tick) begin
          phase_n = ~phase;
          if (phase) begin
            if (bit_cnt == BW'(PREAMBLE_BITS - 1)) begin
              state_n   = ST_SYNC;
              bit_cnt_n = '0;
              shreg_n   = SYNC_WORD;
              last_n    = 1'b0;
            end else begin
              bit_cnt_n = bit_cnt + BW'(1);
            end
          end
        end
      end
      ST_SYNC, ST_DATA: begin
        if (chip_tick) begin
          phase_n = ~phase;
          if (phase) begin
            if (bit_cnt == BW'(7)) begin
              // Byte boundary: finish, reload from hold, or abandon the frame
              bit_cnt_n = '0;
              if (last_q) begin
                state_n = ST_GAP;
              end else if (hold_full) begin
                state_n = ST_DATA;
                shreg_n = hold.data;
                last_n  = hold.last;
                load_c  = 1'b1;
              end else begin
                state_n    = ST_GAP;
                underrun_n = 1'b1;
              end
            end else begin
              bit_cnt_n = bit_cnt + BW'(1);
              shreg_n   = {shreg[6:0], 1'b0};
            end
          end
        end
      end
      ST_GAP: begin
        if (chip_tick) begin
          if (gap_cnt == GW'(GAP_CHIPS - 1)) begin
            state_n   = ST_IDLE;
            gap_cnt_n = '0;
          end else begin
            gap_cnt_n = gap_cnt + GW'(1);
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase

    // Gate level for the chip that starts at the coming edge
    case (state_n)
      ST_PREAMBLE:      gate_n = man_chip(~bit_cnt_n[0], phase_n);
      ST_SYNC, ST_DATA: gate_n = man_chip(shreg_n[7], phase_n);
      default:          gate_n = 1'b0;
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      phase    <= 1'b0;
      bit_cnt  <= '0;
      gap_cnt  <= '0;
      shreg    <= '0;
      last_q   <= 1'b0;
      rf_gate  <= 1'b0;
      busy     <= 1'b0;
      underrun <= 1'b0;
    end else begin
      state    <= state_n;
      phase    <= phase_n;
      bit_cnt  <= bit_cnt_n;
      gap_cnt  <= gap_cnt_n;
      shreg    <= shreg_n;
      last_q   <= last_n;
      rf_gate  <= gate_n;
      busy     <= (state_n != ST_IDLE);
      underrun <= underrun_n;
    end
  end

endmodule

// File: tb/tb_ook_frame_keyer.sv
// Scoreboard bench for ook_frame_keyer: expected chip streams and busy
// lengths are queued when bytes are offered and consumed chip by chip.
module tb_ook_frame_keyer;

  logic clk = 1'b0;
  logic reset_n;

  ook_frame_keyer_if if1();
  ook_frame_keyer_if if2();

  logic gate1, busy1, und1;
  logic gate2, busy2, und2;

  ook_frame_keyer #(
    .CHIP_CYCLES(4), .PREAMBLE_BITS(2), .SYNC_WORD(8'h2D), .GAP_CHIPS(2)
  ) u_dut (
    .clk(clk), .reset_n(reset_n), .tx(if1),
    .rf_gate(gate1), .busy(busy1), .underrun(und1)
  );

  ook_frame_keyer #(
    .CHIP_CYCLES(5)
  ) u_dflt (
    .clk(clk), .reset_n(reset_n), .tx(if2),
    .rf_gate(gate2), .busy(busy2), .underrun(und2)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  logic chip_q[$];
  int   len_q[$];

  int und_cnt1 = 0;
  int und_cnt2 = 0;
  always @(negedge clk) begin
    if (und1 === 1'b1) und_cnt1++;
    if (und2 === 1'b1) und_cnt2++;
  end

  logic sel = 1'b0;
  logic m_busy, m_gate;
  assign m_busy = sel ? busy2 : busy1;
  assign m_gate = sel ? gate2 : gate1;

  task automatic push_bit(input logic b);
    chip_q.push_back(b);
    chip_q.push_back(~b);
  endtask

  task automatic push_frame(input int pb, input int g, input int cyc,
                            input logic [7:0] d0, input logic [7:0] d1, input int nb);
    logic [7:0] sync;
    sync = 8'h2D;
    for (int i = 0; i < pb; i++) push_bit(i % 2 == 0);
    for (int i = 7; i >= 0; i--) push_bit(sync[i]);
    for (int i = 7; i >= 0; i--) push_bit(d0[i]);
    if (nb > 1) for (int i = 7; i >= 0; i--) push_bit(d1[i]);
    for (int i = 0; i < g; i++) chip_q.push_back(1'b0);
    len_q.push_back((2 * (pb + 8 + 8 * nb) + g) * cyc);
  endtask

  // Consume one frame: per chip, level must be constant for cyc clocks
  task automatic watch_frame(input int cyc);
    int t, len, exp_len;
    logic first, stable, exp;
    t = 0;
    while (m_busy !== 1'b1 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk("busy_rise", m_busy, 1);
    if (m_busy !== 1'b1) return;
    len = 0;
    while (m_busy === 1'b1 && len < 5000) begin
      first  = m_gate;
      stable = 1'b1;
      for (int i = 0; i < cyc; i++) begin
        if (m_busy !== 1'b1) break;
        if (m_gate !== first) stable = 1'b0;
        len++;
        @(negedge clk);
      end
      if (chip_q.size() > 0) exp = chip_q.pop_front();
      else exp = 1'bx;
      chk("chip", {stable, first}, {1'b1, exp});
    end
    if (len_q.size() > 0) exp_len = len_q.pop_front();
    else exp_len = -1;
    chk("busy_len", len, exp_len);
    chk("chip_q_left", chip_q.size(), 0);
    chip_q.delete();
  endtask

  // Offer a byte on if1 from a negedge; returns negedges spent waiting for ready
  task automatic send1(input logic [7:0] d, input logic l, input bit jitter, output int waited);
    waited = 0;
    if1.tx_valid = 1'b1;
    if1.tx_data  = d;
    if1.tx_last  = l;
    while (if1.tx_ready !== 1'b1 && waited < 3000) begin
      if (jitter) begin
        if1.tx_data = 8'($urandom);
        if1.tx_last = 1'($urandom);
      end
      @(negedge clk);
      waited++;
    end
    if1.tx_data = d;
    if1.tx_last = l;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, u0, t;
    reset_n      = 1'b0;
    if1.tx_valid = 1'b0;
    if1.tx_data  = '0;
    if1.tx_last  = 1'b0;
    if2.tx_valid = 1'b0;
    if2.tx_data  = '0;
    if2.tx_last  = 1'b0;
    repeat (3) @(negedge clk);

    chk("rst_gate", gate1, 0);
    chk("rst_busy", busy1, 0);
    chk("rst_und", und1, 0);
    chk("rst_ready", if1.tx_ready, 1);
    reset_n = 1'b1;
    @(negedge clk);

    // single byte 0xA5 with last; busy rises two edges after acceptance
    push_frame(2, 2, 4, 8'hA5, 8'h00, 1);
    fork
      watch_frame(4);
      begin
        send1(8'hA5, 1'b1, 1'b0, w);
        if1.tx_valid = 1'b0;
        chk("lat_n0", busy1, 0);
        @(negedge clk);
        chk("lat_n1", busy1, 0);
        @(negedge clk);
        chk("lat_n2_busy", busy1, 1);
        chk("lat_n2_gate", gate1, 1);
      end
    join
    chk("t1_ready", if1.tx_ready, 1);
    chk("t1_und", und_cnt1, 0);

    // back-to-back 0x00, 0xFF(last) with valid held high
    push_frame(2, 2, 4, 8'h00, 8'hFF, 2);
    fork
      watch_frame(4);
      begin
        send1(8'h00, 1'b0, 1'b0, w);
        send1(8'hFF, 1'b1, 1'b0, w);
        if1.tx_valid = 1'b0;
        chk("t2_wait", w, 2 + 2 * (2 + 8) * 4);
      end
    join
    chk("t2_und", und_cnt1, 0);

    // underrun: 0x3C without last, then nothing
    u0 = und_cnt1;
    push_frame(2, 2, 4, 8'h3C, 8'h00, 1);
    fork
      watch_frame(4);
      begin
        send1(8'h3C, 1'b0, 1'b0, w);
        if1.tx_valid = 1'b0;
      end
    join
    chk("t3_und", und_cnt1 - u0, 1);
    chk("t3_ready", if1.tx_ready, 1);
    push_frame(2, 2, 4, 8'h81, 8'h00, 1);
    fork
      watch_frame(4);
      begin
        send1(8'h81, 1'b1, 1'b0, w);
        if1.tx_valid = 1'b0;
      end
    join
    chk("t3_und_after", und_cnt1 - u0, 1);

    // asynchronous reset in the middle of SYNC (chip 7 of the frame)
    send1(8'h66, 1'b1, 1'b0, w);
    if1.tx_valid = 1'b0;
    t = 0;
    while (busy1 !== 1'b1 && t < 100) begin
      @(negedge clk);
      t++;
    end
    repeat (7 * 4 + 1) @(negedge clk);
    #2;
    chk("t4_pre_busy", busy1, 1);
    chk("t4_pre_gate", gate1, 1);
    chk("t4_pre_ready", if1.tx_ready, 0);
    reset_n = 1'b0;
    #1;
    chk("t4_gate", gate1, 0);
    chk("t4_busy", busy1, 0);
    chk("t4_ready", if1.tx_ready, 1);
    chk("t4_und", und1, 0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("t4_idle_busy", busy1, 0);
    push_frame(2, 2, 4, 8'hC3, 8'h00, 1);
    fork
      watch_frame(4);
      begin
        send1(8'hC3, 1'b1, 1'b0, w);
        if1.tx_valid = 1'b0;
      end
    join

    // backpressure: second byte pending with data jitter while not ready
    push_frame(2, 2, 4, 8'h5A, 8'h96, 2);
    fork
      watch_frame(4);
      begin
        send1(8'h5A, 1'b0, 1'b0, w);
        send1(8'h96, 1'b1, 1'b1, w);
        if1.tx_valid = 1'b0;
        chk("t5_wait", w, 2 + 2 * (2 + 8) * 4);
      end
    join

    // default preamble/gap lengths, 5-clock chips
    sel = 1'b1;
    chk("t6_ready0", if2.tx_ready, 1);
    push_frame(16, 32, 5, 8'hE1, 8'h00, 1);
    fork
      watch_frame(5);
      begin
        if2.tx_valid = 1'b1;
        if2.tx_data  = 8'hE1;
        if2.tx_last  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if2.tx_valid = 1'b0;
      end
    join
    chk("t6_ready", if2.tx_ready, 1);
    chk("t6_und", und_cnt2, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
